// File: rtl/canny_pkg.sv
// Shared types and constants for the Canny pipeline stages.
package canny_pkg;

    localparam int unsigned PIXEL_W_DEFAULT = 8;
    localparam int unsigned WIN_TAPS        = 9;

    typedef logic [PIXEL_W_DEFAULT-1:0] pixel_t;

    typedef enum logic [1:0] {
        S_FILL,
        S_RUN,
        S_DONE
    } win_state_t;

endpackage

// File: rtl/line_window_3x3_line_buffer.sv
// One-line pixel store: single write port and combinational read at the same index.
module line_buffer #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned WIDTH = 8,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    idx,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata
);

    // Contents are intentionally not reset; every location is written before it is used.
    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[idx] <= wdata;
        end
    end

    assign rdata = mem_q[idx];

endmodule

// File: rtl/line_window_3x3.sv
// Raster-scan 3x3 neighbourhood former: two line buffers plus a sliding column window.
module line_window_3x3
    import canny_pkg::*;
#(
    parameter int unsigned PIXEL_W = PIXEL_W_DEFAULT,
    parameter int unsigned IMG_W   = 16,
    parameter int unsigned IMG_H   = 16,
    parameter int unsigned CW      = $clog2(IMG_W),
    parameter int unsigned RW      = $clog2(IMG_H)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [PIXEL_W-1:0]            in_pixel,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [WIN_TAPS*PIXEL_W-1:0]   out_window,
    output logic [RW-1:0]                 out_row,
    output logic [CW-1:0]                 out_col,
    output logic                          frame_done
);

    win_state_t state_q, state_d;

    logic [CW-1:0] col_q, col_d;
    logic [RW-1:0] row_q, row_d;

    logic [PIXEL_W-1:0] mid_q   [3];
    logic [PIXEL_W-1:0] mid_d   [3];
    logic [PIXEL_W-1:0] right_q [3];
    logic [PIXEL_W-1:0] right_d [3];
    logic [PIXEL_W-1:0] new_col [3];

    logic                        out_valid_q, out_valid_d;
    logic [WIN_TAPS*PIXEL_W-1:0] out_window_q, out_window_d;
    logic [RW-1:0]               out_row_q, out_row_d;
    logic [CW-1:0]               out_col_q, out_col_d;

    logic [PIXEL_W-1:0] lb0_rd, lb1_rd;
    logic               accept;
    logic               last_col;
    logic               last_row;
    logic               emit;

    assign accept   = in_valid & in_ready;
    assign last_col = (col_q == CW'(IMG_W - 1));
    assign last_row = (row_q == RW'(IMG_H - 1));
    assign emit     = accept & (row_q >= RW'(2)) & (col_q >= CW'(2));

    line_buffer #(
        .DEPTH (IMG_W),
        .WIDTH (PIXEL_W),
        .AW    (CW)
    ) u_lb0 (
        .clk   (clk),
        .we    (accept),
        .idx   (col_q),
        .wdata (lb1_rd),
        .rdata (lb0_rd)
    );

    line_buffer #(
        .DEPTH (IMG_W),
        .WIDTH (PIXEL_W),
        .AW    (CW)
    ) u_lb1 (
        .clk   (clk),
        .we    (accept),
        .idx   (col_q),
        .wdata (in_pixel),
        .rdata (lb1_rd)
    );

    // Top to bottom: two lines ago, previous line, current pixel.
    assign new_col[0] = lb0_rd;
    assign new_col[1] = lb1_rd;
    assign new_col[2] = in_pixel;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_FILL;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_FILL: begin
                if (accept && last_col && (row_q == RW'(1))) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (accept && last_col && last_row) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_FILL;
            end
            default: begin
                state_d = S_FILL;
            end
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        in_ready   = (state_q != S_DONE) && (!out_valid_q || out_ready);
        frame_done = (state_q == S_DONE);
    end

    // ---------------- Datapath registers ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            col_q        <= '0;
            row_q        <= '0;
            out_valid_q  <= 1'b0;
            out_window_q <= '0;
            out_row_q    <= '0;
            out_col_q    <= '0;
        end else begin
            col_q        <= col_d;
            row_q        <= row_d;
            out_valid_q  <= out_valid_d;
            out_window_q <= out_window_d;
            out_row_q    <= out_row_d;
            out_col_q    <= out_col_d;
        end
    end

    // Column registers carry no reset: stale columns are shifted out before any emit (col>=2).
    always_ff @(posedge clk) begin
        mid_q   <= mid_d;
        right_q <= right_d;
    end

    // ---------------- Datapath next state ----------------
    always_comb begin
        col_d        = col_q;
        row_d        = row_q;
        mid_d        = mid_q;
        right_d      = right_q;
        out_valid_d  = out_valid_q;
        out_window_d = out_window_q;
        out_row_d    = out_row_q;
        out_col_d    = out_col_q;

        if (accept) begin
            if (last_col) begin
                col_d = '0;
                row_d = last_row ? '0 : row_q + RW'(1);
            end else begin
                col_d = col_q + CW'(1);
            end
            mid_d   = mid_q;
            mid_d   = right_q;
            right_d = new_col;
        end

        if (emit) begin
            out_valid_d = 1'b1;
            for (int unsigned r = 0; r < 3; r++) begin
                out_window_d[PIXEL_W*(3*r+0) +: PIXEL_W] = mid_q[r];
                out_window_d[PIXEL_W*(3*r+1) +: PIXEL_W] = right_q[r];
                out_window_d[PIXEL_W*(3*r+2) +: PIXEL_W] = new_col[r];
            end
            out_row_d = row_q - RW'(1);
            out_col_d = col_q - CW'(1);
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_window = out_window_q;
    assign out_row    = out_row_q;
    assign out_col    = out_col_q;

endmodule

// File: tb/tb_line_window_3x3.sv
// Directed bench for line_window_3x3 with a frame-image reference model and per-cycle checker.
module tb_line_window_3x3;
    import canny_pkg::*;

    localparam int unsigned W  = 4;
    localparam int unsigned H  = 4;
    localparam int unsigned PW = 8;
    localparam int unsigned WB = 9 * PW;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    pixel_t        in_pixel;
    logic          out_valid;
    logic          out_ready;
    logic [WB-1:0] out_window;
    logic [1:0]    out_row;
    logic [1:0]    out_col;
    logic          frame_done;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    typedef struct {
        logic [WB-1:0] win;
        int            row;
        int            col;
    } win_t;

    win_t   exp_q[$];
    win_t   got_log[$];
    pixel_t img [H][W];
    int     n_acc  = 0;
    bit     fd_exp = 1'b0;

    always #5 clk = ~clk;

    line_window_3x3 #(
        .PIXEL_W (PW),
        .IMG_W   (W),
        .IMG_H   (H)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_pixel   (in_pixel),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_window (out_window),
        .out_row    (out_row),
        .out_col    (out_col),
        .frame_done (frame_done)
    );

    task automatic chk(input string name, input logic [WB-1:0] act, input logic [WB-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: raster position from the accept count, windows cut from a frame image.
    always @(posedge clk) begin
        int   r, c;
        win_t e;
        if (rst) begin
            exp_q.delete();
            n_acc  = 0;
            fd_exp = 1'b0;
        end else begin
            if (out_valid && out_ready) begin
                got_log.push_back('{out_window, int'(out_row), int'(out_col)});
                if (exp_q.size() != 0) void'(exp_q.pop_front());
            end
            fd_exp = 1'b0;
            if (in_valid && in_ready) begin
                r = (n_acc / W) % H;
                c = n_acc % W;
                img[r][c] = in_pixel;
                if (r >= 2 && c >= 2) begin
                    e.win = '0;
                    for (int rr = 0; rr < 3; rr++)
                        for (int cc = 0; cc < 3; cc++)
                            e.win[PW*(3*rr+cc) +: PW] = img[r-2+rr][c-2+cc];
                    e.row = r - 1;
                    e.col = c - 1;
                    exp_q.push_back(e);
                end
                if (r == H-1 && c == W-1) fd_exp = 1'b1;
                n_acc = (n_acc + 1) % (W * H);
            end
        end
    end

    // Per-cycle compare, sampled mid-low-phase.
    always @(negedge clk) begin
        if (chk_en) begin
            #2;
            chk("out_valid", WB'(out_valid), WB'(exp_q.size() != 0));
            if (exp_q.size() != 0) begin
                chk("out_window", out_window, exp_q[0].win);
                chk("out_row", WB'(out_row), WB'(exp_q[0].row));
                chk("out_col", WB'(out_col), WB'(exp_q[0].col));
            end
            chk("frame_done", WB'(frame_done), WB'(fd_exp));
            chk("in_ready", WB'(in_ready), WB'(!fd_exp && (exp_q.size() == 0 || out_ready)));
        end
    end

    task automatic push_pixel(input pixel_t p, input int gap);
        int guard;
        while (gap > 0 && int'($urandom_range(99)) < gap) @(negedge clk);
        in_valid = 1'b1;
        in_pixel = p;
        guard    = 0;
        #1;
        while (!in_ready) begin
            if (guard == 200) begin
                total++;
                bad++;
                $display("FAIL push_timeout: pixel %h not accepted in %0d cycles", p, guard);
                in_valid = 1'b0;
                return;
            end
            guard++;
            @(negedge clk);
            #1;
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic push_range(input int first, input int last, input pixel_t off, input int gap);
        for (int i = first; i <= last; i++)
            push_pixel(pixel_t'(int'(off) + 16 * (i / W) + (i % W)), gap);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    localparam logic [WB-1:0] WIN_FIRST = 72'h222120121110020100;
    localparam logic [WB-1:0] WIN_LAST  = 72'h333231232221131211;
    localparam logic [WB-1:0] WIN_HI    = 72'hA2A1A0929190828180;

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_pixel  = '0;
        out_ready = 1'b1;
        idle(3);
        chk("rst_out_valid", WB'(out_valid), '0);
        chk("rst_out_window", out_window, '0);
        chk("rst_out_row", WB'(out_row), '0);
        chk("rst_out_col", WB'(out_col), '0);
        chk("rst_frame_done", WB'(frame_done), '0);
        chk("rst_in_ready", WB'(in_ready), WB'(1));
        rst    = 1'b0;
        chk_en = 1'b1;

        // Gap-free frame with frame_done timing.
        got_log.delete();
        push_range(0, 15, 8'h00, 0);
        chk("fd_pulse", WB'(frame_done), WB'(1));
        chk("fd_in_ready", WB'(in_ready), '0);
        @(negedge clk);
        chk("fd_one_cycle", WB'(frame_done), '0);
        idle(3);
        chk("f1_count", WB'(got_log.size()), WB'(4));
        if (got_log.size() == 4) begin
            chk("f1_first_win", got_log[0].win, WIN_FIRST);
            chk("f1_first_row", WB'(got_log[0].row), WB'(1));
            chk("f1_first_col", WB'(got_log[0].col), WB'(1));
            chk("f1_last_win", got_log[3].win, WIN_LAST);
            chk("f1_last_row", WB'(got_log[3].row), WB'(2));
            chk("f1_last_col", WB'(got_log[3].col), WB'(2));
        end

        // Back-pressure while the first window is pending.
        got_log.delete();
        out_ready = 1'b0;
        push_range(0, 10, 8'h00, 0);
        in_valid = 1'b1;
        in_pixel = 8'h23;
        repeat (5) begin
            #1;
            chk("stall_in_ready", WB'(in_ready), '0);
            chk("stall_valid", WB'(out_valid), WB'(1));
            chk("stall_window", out_window, WIN_FIRST);
            @(negedge clk);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        push_range(11, 15, 8'h00, 0);
        idle(3);
        chk("stall_count", WB'(got_log.size()), WB'(4));
        if (got_log.size() == 4) chk("stall_first_win", got_log[0].win, WIN_FIRST);

        // Random input gaps.
        got_log.delete();
        push_range(0, 15, 8'h00, 50);
        idle(3);
        chk("gap_count", WB'(got_log.size()), WB'(4));
        if (got_log.size() == 4) begin
            chk("gap_first_win", got_log[0].win, WIN_FIRST);
            chk("gap_last_win", got_log[3].win, WIN_LAST);
        end

        // Back-to-back frames, second offset by 0x80.
        got_log.delete();
        push_range(0, 15, 8'h00, 0);
        push_range(0, 15, 8'h80, 0);
        idle(3);
        chk("b2b_count", WB'(got_log.size()), WB'(8));
        if (got_log.size() == 8) begin
            chk("b2b_f2_first_win", got_log[4].win, WIN_HI);
            chk("b2b_f2_first_row", WB'(got_log[4].row), WB'(1));
            chk("b2b_f2_first_col", WB'(got_log[4].col), WB'(1));
        end

        // Reset mid-frame, then with a pending window.
        push_range(0, 9, 8'h00, 0);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_valid", WB'(out_valid), '0);
        chk("midrst_fd", WB'(frame_done), '0);
        rst       = 1'b0;
        out_ready = 1'b0;
        push_range(0, 10, 8'h00, 0);
        chk("pend_valid", WB'(out_valid), WB'(1));
        rst = 1'b1;
        @(negedge clk);
        chk("pend_drop_valid", WB'(out_valid), '0);
        chk("pend_drop_window", out_window, '0);
        rst       = 1'b0;
        out_ready = 1'b1;
        got_log.delete();
        push_range(0, 15, 8'h00, 0);
        idle(3);
        chk("restart_count", WB'(got_log.size()), WB'(4));
        if (got_log.size() == 4) begin
            chk("restart_first_win", got_log[0].win, WIN_FIRST);
            chk("restart_first_row", WB'(got_log[0].row), WB'(1));
            chk("restart_first_col", WB'(got_log[0].col), WB'(1));
        end

        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
